// File: rtl/mux4_scan_pkg.sv
// Shared types and constants for the 4:1 mux scan sequencer.
// Holds the FSM state encoding and the channel/select sizing.
package mux4_scan_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    OUTPUT = 2'd2
  } state_t;

endpackage

// File: rtl/mux4_scan_next_ch.sv
// Combinational priority picker: finds the next enabled channel above the
// current select, or the lowest enabled channel when starting a fresh scan.
import mux4_scan_pkg::*;

module mux4_scan_next_ch (
  input  logic [NUM_CH-1:0] mask,
  input  logic [SEL_W-1:0]  cur_sel,
  input  logic              from_start,
  output logic [SEL_W-1:0]  next_ch,
  output logic              none_left
);

  logic [NUM_CH-1:0] above_s;
  logic [NUM_CH-1:0] cand_s;

  // Channels strictly above the current select
  always_comb begin
    above_s = 4'b0000;
    case (cur_sel)
      2'd0:    above_s = 4'b1110;
      2'd1:    above_s = 4'b1100;
      2'd2:    above_s = 4'b1000;
      default: above_s = 4'b0000;
    endcase
  end

  assign cand_s = mask & (from_start ? 4'b1111 : above_s);

  // Lowest set candidate wins
  always_comb begin
    next_ch   = 2'd0;
    none_left = 1'b1;
    casez (cand_s)
      4'b???1: begin next_ch = 2'd0; none_left = 1'b0; end
      4'b??10: begin next_ch = 2'd1; none_left = 1'b0; end
      4'b?100: begin next_ch = 2'd2; none_left = 1'b0; end
      4'b1000: begin next_ch = 2'd3; none_left = 1'b0; end
      default: begin next_ch = 2'd0; none_left = 1'b1; end
    endcase
  end

endmodule

// File: rtl/mux4_scan_sequencer.sv
// Drives the select of an external 4:1 mux, samples each enabled channel after
// a settle time, and offers the assembled 4-bit frame over valid/ready.
import mux4_scan_pkg::*;

module mux4_scan_sequencer #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                continuous,
  input  logic [NUM_CH-1:0]   ch_mask,
  input  logic                y_in,
  output logic [SEL_W-1:0]    sel,
  output logic [NUM_CH-1:0]   frame,
  output logic                frame_valid,
  input  logic                frame_ready,
  output logic                busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_t              state_r;
  logic [SEL_W-1:0]    sel_r;
  logic [NUM_CH-1:0]   frame_r;
  logic                valid_r;
  logic                busy_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [NUM_CH-1:0]   mask_r;
  logic                cont_r;

  logic [NUM_CH-1:0]   pick_mask_s;
  logic                from_start_s;
  logic [SEL_W-1:0]    next_ch_s;
  logic                none_left_s;

  // In IDLE the live mask is what gets latched; afterwards only the latched copy counts
  assign pick_mask_s  = (state_r == IDLE) ? ch_mask : mask_r;
  assign from_start_s = (state_r != SETTLE);

  mux4_scan_next_ch u_next_ch (
    .mask       (pick_mask_s),
    .cur_sel    (sel_r),
    .from_start (from_start_s),
    .next_ch    (next_ch_s),
    .none_left  (none_left_s)
  );

  // Scan FSM with registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      sel_r   <= 2'b00;
      frame_r <= 4'b0000;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      cnt_r   <= '0;
      mask_r  <= 4'b0000;
      cont_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            mask_r  <= ch_mask;
            cont_r  <= continuous;
            frame_r <= 4'b0000;
            cnt_r   <= '0;
            busy_r  <= 1'b1;
            if (none_left_s) begin
              state_r <= OUTPUT;
              valid_r <= 1'b1;
            end else begin
              state_r <= SETTLE;
              sel_r   <= next_ch_s;
            end
          end else begin
            busy_r <= 1'b0;
          end
        end

        SETTLE: begin
          if (cnt_r == CNT_LAST) begin
            frame_r[sel_r] <= y_in;
            cnt_r          <= '0;
            if (none_left_s) begin
              state_r <= OUTPUT;
              valid_r <= 1'b1;
            end else begin
              sel_r <= next_ch_s;
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end

        OUTPUT: begin
          if (frame_ready) begin
            if (cont_r) begin
              frame_r <= 4'b0000;
              cnt_r   <= '0;
              if (none_left_s) begin
                // Empty mask in continuous mode keeps offering zero frames
                valid_r <= 1'b1;
              end else begin
                state_r <= SETTLE;
                sel_r   <= next_ch_s;
                valid_r <= 1'b0;
              end
            end else begin
              state_r <= IDLE;
              valid_r <= 1'b0;
              busy_r  <= 1'b0;
            end
          end else begin
            valid_r <= 1'b1;
          end
        end

        default: begin
          state_r <= IDLE;
          valid_r <= 1'b0;
          busy_r  <= 1'b0;
          cnt_r   <= '0;
        end
      endcase
    end
  end

  assign sel         = sel_r;
  assign frame       = frame_r;
  assign frame_valid = valid_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_mux4_scan_sequencer.sv
// Directed self-checking bench for mux4_scan_sequencer (SETTLE_CYCLES=2).
module tb_mux4_scan_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       continuous;
  logic [3:0] ch_mask;
  logic       y_in;
  logic [1:0] sel;
  logic [3:0] frame;
  logic       frame_valid;
  logic       frame_ready;
  logic       busy;
  logic [3:0] mux_in;

  int tests_run;
  int tests_failed;

  mux4_scan_sequencer #(.SETTLE_CYCLES(2), .CNT_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .continuous  (continuous),
    .ch_mask     (ch_mask),
    .y_in        (y_in),
    .sel         (sel),
    .frame       (frame),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .busy        (busy)
  );

  // The external 4:1 mux with constant channel inputs
  assign y_in = mux_in[sel];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    tests_run++;
    if (sel !== 2'b00) begin tests_failed++; $display("FAIL reset_sel got %b want 00", sel); end
    tests_run++;
    if (frame !== 4'b0000) begin tests_failed++; $display("FAIL reset_frame got %b want 0000", frame); end
    tests_run++;
    if (frame_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %b want 0", frame_valid); end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", busy); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_full_scan();
    logic [1:0] exp_sel [8];
    exp_sel = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
    mux_in = 4'b1010; ch_mask = 4'b1111; continuous = 1'b0; frame_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tests_run++;
      if (sel !== exp_sel[k] || frame_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL full_seq[%0d] got sel=%0d valid=%b want sel=%0d valid=0", k, sel, frame_valid, exp_sel[k]);
      end
      tick();
    end
    tests_run++;
    if (frame_valid !== 1'b1 || frame !== 4'b1010) begin
      tests_failed++;
      $display("FAIL full_frame got valid=%b frame=%b want valid=1 frame=1010", frame_valid, frame);
    end
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    tests_run++;
    if (frame_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_done got valid=%b busy=%b want 0 0", frame_valid, busy);
    end
  endtask

  task automatic test_sparse();
    logic [1:0] exp_sel [4];
    exp_sel = '{2'd0, 2'd0, 2'd2, 2'd2};
    mux_in = 4'b1111; ch_mask = 4'b0101;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if (sel !== exp_sel[k] || frame_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL sparse_seq[%0d] got sel=%0d valid=%b want sel=%0d valid=0", k, sel, frame_valid, exp_sel[k]);
      end
      tick();
    end
    tests_run++;
    if (frame_valid !== 1'b1 || frame !== 4'b0101) begin
      tests_failed++;
      $display("FAIL sparse_frame got valid=%b frame=%b want valid=1 frame=0101", frame_valid, frame);
    end
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    mux_in = 4'b0110; ch_mask = 4'b0011;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    // Ch0 samples 0, ch1 samples 1
    tests_run++;
    if (frame_valid !== 1'b1 || frame !== 4'b0010) begin
      tests_failed++;
      $display("FAIL bp_frame got valid=%b frame=%b want valid=1 frame=0010", frame_valid, frame);
    end
    mux_in = 4'b1001;
    ch_mask = 4'b1111;
    for (int k = 0; k < 10; k++) begin
      start = (k == 3) ? 1'b1 : 1'b0;
      tick();
      tests_run++;
      if (frame_valid !== 1'b1 || frame !== 4'b0010 || sel !== 2'd1 || busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL bp_hold[%0d] got valid=%b frame=%b sel=%0d busy=%b want 1 0010 1 1", k, frame_valid, frame, sel, busy);
      end
    end
    start = 1'b0;
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    tests_run++;
    if (frame_valid !== 1'b0 || busy !== 1'b0 || sel !== 2'd1) begin
      tests_failed++;
      $display("FAIL bp_release got valid=%b busy=%b sel=%0d want 0 0 1", frame_valid, busy, sel);
    end
  endtask

  task automatic test_zero_mask();
    ch_mask = 4'b0000;
    start = 1'b1;
    tick();
    start = 1'b0;
    tests_run++;
    if (frame_valid !== 1'b1 || frame !== 4'b0000 || sel !== 2'd1 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL zero_mask got valid=%b frame=%b sel=%0d busy=%b want 1 0000 1 1", frame_valid, frame, sel, busy);
    end
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    tests_run++;
    if (frame_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero_done got valid=%b busy=%b want 0 0", frame_valid, busy);
    end
  endtask

  task automatic test_continuous();
    mux_in = 4'b0001; ch_mask = 4'b0011; continuous = 1'b1; frame_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    continuous = 1'b0;
    ch_mask = 4'b1111;
    repeat (4) tick();
    tests_run++;
    if (frame_valid !== 1'b1 || frame !== 4'b0001) begin
      tests_failed++;
      $display("FAIL cont_first got valid=%b frame=%b want 1 0001", frame_valid, frame);
    end
    mux_in = 4'b0010;
    tick();
    tests_run++;
    if (frame_valid !== 1'b0 || busy !== 1'b1 || sel !== 2'd0) begin
      tests_failed++;
      $display("FAIL cont_restart got valid=%b busy=%b sel=%0d want 0 1 0", frame_valid, busy, sel);
    end
    repeat (3) tick();
    tests_run++;
    if (frame_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL cont_early got valid=%b want 0", frame_valid);
    end
    tick();
    tests_run++;
    if (frame_valid !== 1'b1 || frame !== 4'b0010) begin
      tests_failed++;
      $display("FAIL cont_second got valid=%b frame=%b want 1 0010", frame_valid, frame);
    end
    frame_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    tests_run++;
    if (busy !== 1'b0 || frame_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL cont_stop got busy=%b valid=%b want 0 0", busy, frame_valid);
    end
  endtask

  task automatic test_reset_mid_scan();
    mux_in = 4'b1111; ch_mask = 4'b1111; continuous = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    tests_run++;
    if (sel !== 2'd2 || frame !== 4'b0011) begin
      tests_failed++;
      $display("FAIL mid_pre got sel=%0d frame=%b want 2 0011", sel, frame);
    end
    rst_n = 1'b0;
    start = 1'b1;
    tick();
    tests_run++;
    if (sel !== 2'b00 || frame !== 4'b0000 || frame_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset got sel=%0d frame=%b valid=%b busy=%b want 0 0000 0 0", sel, frame, frame_valid, busy);
    end
    tick();
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_start_in_reset got busy=%b want 0", busy);
    end
    rst_n = 1'b1;
    tick();
    start = 1'b0;
    tests_run++;
    if (busy !== 1'b1 || sel !== 2'd0) begin
      tests_failed++;
      $display("FAIL mid_restart got busy=%b sel=%0d want 1 0", busy, sel);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst_n = 1'b0;
    start = 1'b0;
    continuous = 1'b0;
    ch_mask = 4'b0000;
    frame_ready = 1'b0;
    mux_in = 4'b0000;
    test_reset();
    test_full_scan();
    test_sparse();
    test_backpressure();
    test_zero_mask();
    test_continuous();
    test_reset_mid_scan();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
